// File: rtl/core_types_pkg.sv
// Shared core types: default sizing for the rename stage and the tag types
// derived from it.
package core_types_pkg;

  localparam int unsigned DEF_NUM_ARCH_REGS      = 32;
  localparam int unsigned DEF_NUM_PHYS_REGS      = 64;
  localparam int unsigned DEF_CHECKPOINT_COLUMNS = 4;
  localparam int unsigned DEF_RENAME_WIDTH       = 2;
  localparam int unsigned DEF_ROB_INDEX_W        = 4;

  localparam int unsigned ARCH_TAG_W  = $clog2(DEF_NUM_ARCH_REGS);
  localparam int unsigned PHYS_TAG_W  = $clog2(DEF_NUM_PHYS_REGS);
  localparam int unsigned CKPT_COL_W  = $clog2(DEF_CHECKPOINT_COLUMNS);

  typedef logic [PHYS_TAG_W-1:0]      phys_reg_tag_t;
  typedef logic [ARCH_TAG_W-1:0]      arch_reg_tag_t;
  typedef logic [CKPT_COL_W-1:0]      checkpoint_column_t;
  typedef logic [DEF_ROB_INDEX_W-1:0] ROB_index_t;

endpackage

// File: rtl/phys_reg_map_table_ss_bypass.sv
// Intra-group rename bypass: younger lanes see the mappings created by older
// lanes of the same group; arch reg 0 always maps to phys 0.
module rename_bypass_net
  import core_types_pkg::*;
#(
  parameter int unsigned RENAME_WIDTH = DEF_RENAME_WIDTH,
  parameter int unsigned AW           = ARCH_TAG_W,
  parameter int unsigned PW           = PHYS_TAG_W
) (
  input  logic [RENAME_WIDTH-1:0][1:0][AW-1:0] src_arch_tag,
  input  logic [RENAME_WIDTH-1:0][1:0][PW-1:0] src_base_tag,
  input  logic [RENAME_WIDTH-1:0]              rename_valid,
  input  logic [RENAME_WIDTH-1:0][AW-1:0]      dest_arch_tag,
  input  logic [RENAME_WIDTH-1:0][PW-1:0]      dest_phys_tag,
  input  logic [RENAME_WIDTH-1:0][PW-1:0]      old_base_tag,
  output logic [RENAME_WIDTH-1:0][1:0][PW-1:0] src_phys_tag,
  output logic [RENAME_WIDTH-1:0][PW-1:0]      old_phys_tag
);

  always_comb begin
    src_phys_tag = src_base_tag;
    old_phys_tag = old_base_tag;
    for (int unsigned j = 0; j < RENAME_WIDTH; j++) begin
      // ascending scan so the highest older lane overrides
      for (int unsigned i = 0; i < j; i++) begin
        if (rename_valid[i]) begin
          if (dest_arch_tag[i] == dest_arch_tag[j]) old_phys_tag[j] = dest_phys_tag[i];
          for (int unsigned k = 0; k < 2; k++)
            if (dest_arch_tag[i] == src_arch_tag[j][k]) src_phys_tag[j][k] = dest_phys_tag[i];
        end
      end
      if (dest_arch_tag[j] == '0) old_phys_tag[j] = '0;
      for (int unsigned k = 0; k < 2; k++)
        if (src_arch_tag[j][k] == '0) src_phys_tag[j][k] = '0;
    end
  end

endmodule

// File: rtl/phys_reg_map_table_ss.sv
// Superscalar register map table with a circular FIFO of checkpoint columns
// for branch save, in-order release and mispredict restore.
module phys_reg_map_table_ss
  import core_types_pkg::*;
#(
  parameter int unsigned NUM_ARCH_REGS      = DEF_NUM_ARCH_REGS,
  parameter int unsigned NUM_PHYS_REGS      = DEF_NUM_PHYS_REGS,
  parameter int unsigned CHECKPOINT_COLUMNS = DEF_CHECKPOINT_COLUMNS,
  parameter int unsigned RENAME_WIDTH       = DEF_RENAME_WIDTH,
  parameter int unsigned ROB_INDEX_W        = DEF_ROB_INDEX_W,
  localparam int unsigned AW = $clog2(NUM_ARCH_REGS),
  localparam int unsigned PW = $clog2(NUM_PHYS_REGS),
  localparam int unsigned CW = $clog2(CHECKPOINT_COLUMNS),
  localparam int unsigned LW = (RENAME_WIDTH > 1) ? $clog2(RENAME_WIDTH) : 1
) (
  input  logic                                 CLK,
  input  logic                                 nRST,
  input  logic [RENAME_WIDTH-1:0][1:0][AW-1:0] src_arch_tag,
  output logic [RENAME_WIDTH-1:0][1:0][PW-1:0] src_phys_tag,
  input  logic [RENAME_WIDTH-1:0]              rename_valid,
  input  logic [RENAME_WIDTH-1:0][AW-1:0]      rename_dest_arch_tag,
  input  logic [RENAME_WIDTH-1:0][PW-1:0]      rename_dest_phys_tag,
  output logic [RENAME_WIDTH-1:0][PW-1:0]      rename_old_phys_tag,
  input  logic                                 save_valid,
  input  logic [LW-1:0]                        save_lane,
  input  logic [ROB_INDEX_W-1:0]               save_ROB_index,
  output logic                                 save_ready,
  output logic [CW-1:0]                        save_column,
  input  logic                                 release_valid,
  input  logic [ROB_INDEX_W-1:0]               release_ROB_index,
  output logic                                 release_success,
  input  logic                                 restore_valid,
  input  logic [CW-1:0]                        restore_column,
  input  logic [ROB_INDEX_W-1:0]               restore_ROB_index,
  output logic                                 restore_success,
  input  logic                                 revert_valid,
  input  logic [AW-1:0]                        revert_dest_arch_tag,
  input  logic [PW-1:0]                        revert_safe_phys_tag,
  input  logic [PW-1:0]                        revert_spec_phys_tag,
  output logic [CW-1:0]                        ckpt_count
);

  typedef struct packed {
    logic                                valid;
    logic [ROB_INDEX_W-1:0]              rob;
    logic [NUM_ARCH_REGS-1:0][PW-1:0]    map;
  } column_t;

  column_t cols [CHECKPOINT_COLUMNS];
  logic [CW-1:0] working, working_nxt, count, oldest;
  logic [NUM_ARCH_REGS-1:0][PW-1:0] work_map, map_partial, map_full;
  logic [RENAME_WIDTH-1:0][1:0][PW-1:0] src_base;
  logic [RENAME_WIDTH-1:0][PW-1:0] old_base;
  logic save_go, revert_go;

  assign work_map    = cols[working].map;
  assign working_nxt = working + CW'(1);
  assign oldest      = working - count;

  always_comb begin
    src_base = '0;
    old_base = '0;
    for (int unsigned j = 0; j < RENAME_WIDTH; j++) begin
      old_base[j] = work_map[rename_dest_arch_tag[j]];
      for (int unsigned k = 0; k < 2; k++) src_base[j][k] = work_map[src_arch_tag[j][k]];
    end
  end

  rename_bypass_net #(
    .RENAME_WIDTH(RENAME_WIDTH),
    .AW(AW),
    .PW(PW)
  ) u_bypass (
    .src_arch_tag (src_arch_tag),
    .src_base_tag (src_base),
    .rename_valid (rename_valid),
    .dest_arch_tag(rename_dest_arch_tag),
    .dest_phys_tag(rename_dest_phys_tag),
    .old_base_tag (old_base),
    .src_phys_tag (src_phys_tag),
    .old_phys_tag (rename_old_phys_tag)
  );

  // map_partial is the checkpoint image: only lanes up to the branch lane
  always_comb begin
    map_full    = work_map;
    map_partial = work_map;
    for (int unsigned i = 0; i < RENAME_WIDTH; i++) begin
      if (rename_valid[i] && rename_dest_arch_tag[i] != '0) begin
        map_full[rename_dest_arch_tag[i]] = rename_dest_phys_tag[i];
        if (i <= 32'(save_lane)) map_partial[rename_dest_arch_tag[i]] = rename_dest_phys_tag[i];
      end
    end
  end

  assign save_ready      = (count != CW'(CHECKPOINT_COLUMNS - 1));
  assign save_column     = working;
  assign ckpt_count      = count;
  assign restore_success = restore_valid && cols[restore_column].valid &&
                           (cols[restore_column].rob == restore_ROB_index) &&
                           (restore_column != working);
  assign release_success = release_valid && (count != '0) && cols[oldest].valid &&
                           (cols[oldest].rob == release_ROB_index) &&
                           !(restore_success && (restore_column == oldest));
  assign revert_go       = revert_valid && !restore_success;
  assign save_go         = save_valid && save_ready && !restore_success && !revert_valid;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned c = 0; c < CHECKPOINT_COLUMNS; c++) cols[c] <= '0;
      for (int unsigned a = 0; a < NUM_ARCH_REGS; a++) cols[0].map[a] <= PW'(a);
      cols[0].valid <= 1'b1;
      working       <= '0;
      count         <= '0;
    end else begin
      if (release_success) cols[oldest].valid <= 1'b0;
      if (restore_success) begin
        working <= restore_column;
        for (int unsigned k = 1; k < CHECKPOINT_COLUMNS; k++)
          if (CW'(k) <= CW'(working - restore_column))
            cols[CW'(restore_column + CW'(k))].valid <= 1'b0;
        count <= restore_column - oldest - CW'(release_success);
      end else begin
        if (revert_go) begin
          if (revert_dest_arch_tag != '0) cols[working].map[revert_dest_arch_tag] <= revert_safe_phys_tag;
        end else if (save_go) begin
          cols[working].map       <= map_partial;
          cols[working].rob       <= save_ROB_index;
          cols[working_nxt].map   <= map_full;
          cols[working_nxt].valid <= 1'b1;
          working                 <= working_nxt;
        end else begin
          cols[working].map <= map_full;
        end
        count <= count + CW'(save_go) - CW'(release_success);
      end
    end
  end

  revert_matches_spec: assert property (@(posedge CLK) disable iff (!nRST)
    revert_go |-> (work_map[revert_dest_arch_tag] == revert_spec_phys_tag));

endmodule

// File: tb/tb_phys_reg_map_table_ss.sv
// Directed bench for phys_reg_map_table_ss: bypass, save/fill, restore,
// release across a pointer wrap, revert, arch 0 and mid-run reset.
module tb_phys_reg_map_table_ss;
  import core_types_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned PW = 6;
  localparam int unsigned CW = 2;

  logic                   CLK = 1'b0;
  logic                   nRST;
  logic [1:0][1:0][AW-1:0] src_arch_tag;
  logic [1:0][1:0][PW-1:0] src_phys_tag;
  logic [1:0]             rename_valid;
  logic [1:0][AW-1:0]     rename_dest_arch_tag;
  logic [1:0][PW-1:0]     rename_dest_phys_tag;
  logic [1:0][PW-1:0]     rename_old_phys_tag;
  logic                   save_valid;
  logic [0:0]             save_lane;
  logic [3:0]             save_ROB_index;
  logic                   save_ready;
  logic [CW-1:0]          save_column;
  logic                   release_valid;
  logic [3:0]             release_ROB_index;
  logic                   release_success;
  logic                   restore_valid;
  logic [CW-1:0]          restore_column;
  logic [3:0]             restore_ROB_index;
  logic                   restore_success;
  logic                   revert_valid;
  logic [AW-1:0]          revert_dest_arch_tag;
  logic [PW-1:0]          revert_safe_phys_tag;
  logic [PW-1:0]          revert_spec_phys_tag;
  logic [CW-1:0]          ckpt_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  phys_reg_map_table_ss #(
    .NUM_ARCH_REGS(32),
    .NUM_PHYS_REGS(64),
    .CHECKPOINT_COLUMNS(4),
    .RENAME_WIDTH(2),
    .ROB_INDEX_W(4)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .src_arch_tag(src_arch_tag), .src_phys_tag(src_phys_tag),
    .rename_valid(rename_valid), .rename_dest_arch_tag(rename_dest_arch_tag),
    .rename_dest_phys_tag(rename_dest_phys_tag), .rename_old_phys_tag(rename_old_phys_tag),
    .save_valid(save_valid), .save_lane(save_lane), .save_ROB_index(save_ROB_index),
    .save_ready(save_ready), .save_column(save_column),
    .release_valid(release_valid), .release_ROB_index(release_ROB_index),
    .release_success(release_success),
    .restore_valid(restore_valid), .restore_column(restore_column),
    .restore_ROB_index(restore_ROB_index), .restore_success(restore_success),
    .revert_valid(revert_valid), .revert_dest_arch_tag(revert_dest_arch_tag),
    .revert_safe_phys_tag(revert_safe_phys_tag), .revert_spec_phys_tag(revert_spec_phys_tag),
    .ckpt_count(ckpt_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic idle();
    src_arch_tag = '0; rename_valid = '0; rename_dest_arch_tag = '0; rename_dest_phys_tag = '0;
    save_valid = 1'b0; save_lane = '0; save_ROB_index = '0;
    release_valid = 1'b0; release_ROB_index = '0;
    restore_valid = 1'b0; restore_column = '0; restore_ROB_index = '0;
    revert_valid = 1'b0; revert_dest_arch_tag = '0; revert_safe_phys_tag = '0; revert_spec_phys_tag = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ren(input int lane, input logic [AW-1:0] a, input logic [PW-1:0] p);
    rename_valid[lane] = 1'b1;
    rename_dest_arch_tag[lane] = a;
    rename_dest_phys_tag[lane] = p;
  endtask

  task automatic save(input logic [0:0] lane, input logic [3:0] rob);
    save_valid = 1'b1; save_lane = lane; save_ROB_index = rob;
  endtask

  // lane 0 source 0 has no older lane, so it shows the working column directly
  task automatic expect_map(input string tag, input logic [AW-1:0] a, input logic [PW-1:0] p);
    src_arch_tag[0][0] = a;
    #1;
    check(tag, 32'(src_phys_tag[0][0]), 32'(p));
  endtask

  task automatic do_release(input string tag, input logic [3:0] rob, input logic exp);
    release_valid = 1'b1; release_ROB_index = rob;
    #1;
    check(tag, 32'(release_success), 32'(exp));
    tick(); idle();
  endtask

  initial begin
    idle();
    nRST = 1'b1;
    #1 nRST = 1'b0;
    @(negedge CLK);
    expect_map("rst_r5", 5'd5, 6'd5);
    check("rst_ready", 32'(save_ready), 1);
    check("rst_count", 32'(ckpt_count), 0);
    check("rst_col", 32'(save_column), 0);
    check("rst_rel", 32'(release_success), 0);
    check("rst_rest", 32'(restore_success), 0);
    #1 nRST = 1'b1;
    tick();

    // dual rename of r3 with a lane1 dependency
    ren(0, 5'd3, 6'd40); ren(1, 5'd3, 6'd41);
    src_arch_tag[0][0] = 5'd3; src_arch_tag[1][0] = 5'd3;
    #1;
    check("byp_l0_src", 32'(src_phys_tag[0][0]), 3);
    check("byp_l1_src", 32'(src_phys_tag[1][0]), 40);
    check("byp_old0", 32'(rename_old_phys_tag[0]), 3);
    check("byp_old1", 32'(rename_old_phys_tag[1]), 40);
    tick(); idle();
    expect_map("r3_next", 5'd3, 6'd41);

    // save on lane 0 with lane 1 renaming the same reg
    ren(0, 5'd4, 6'd50); ren(1, 5'd4, 6'd51); save(1'b0, 4'd7);
    #1;
    check("save_col0", 32'(save_column), 0);
    tick(); idle();
    check("save_count1", 32'(ckpt_count), 1);
    check("save_col1", 32'(save_column), 1);
    expect_map("w1_r4", 5'd4, 6'd51);
    expect_map("w1_r3", 5'd3, 6'd41);

    // fill the remaining columns
    ren(0, 5'd5, 6'd20); save(1'b1, 4'd9);
    tick(); idle();
    save(1'b0, 4'd11);
    tick(); idle();
    #1;
    check("full_count", 32'(ckpt_count), 3);
    check("full_ready", 32'(save_ready), 0);
    check("full_col", 32'(save_column), 3);
    expect_map("w3_r5", 5'd5, 6'd20);
    ren(0, 5'd6, 6'd30); save(1'b0, 4'd13);
    tick(); idle();
    check("full_ign_count", 32'(ckpt_count), 3);
    check("full_ign_col", 32'(save_column), 3);
    expect_map("full_ign_r6", 5'd6, 6'd30);

    // restore: wrong tag then the right one
    restore_valid = 1'b1; restore_column = 2'd1; restore_ROB_index = 4'd8;
    #1;
    check("rest_bad", 32'(restore_success), 0);
    tick(); idle();
    check("rest_bad_count", 32'(ckpt_count), 3);
    restore_valid = 1'b1; restore_column = 2'd1; restore_ROB_index = 4'd9;
    ren(0, 5'd7, 6'd33);
    #1;
    check("rest_ok", 32'(restore_success), 1);
    tick(); idle();
    check("rest_count", 32'(ckpt_count), 1);
    check("rest_working", 32'(save_column), 1);
    expect_map("rest_r5", 5'd5, 6'd20);
    expect_map("rest_r4", 5'd4, 6'd51);
    expect_map("rest_r6", 5'd6, 6'd6);
    expect_map("rest_r7", 5'd7, 6'd7);
    tick();
    restore_valid = 1'b1; restore_column = 2'd2; restore_ROB_index = 4'd11;
    #1;
    check("rest_col2_inval", 32'(restore_success), 0);
    tick(); idle();

    // back to column 0 to see the lane-0-only checkpoint image
    restore_valid = 1'b1; restore_column = 2'd0; restore_ROB_index = 4'd7;
    #1;
    check("rest0_ok", 32'(restore_success), 1);
    tick(); idle();
    check("rest0_count", 32'(ckpt_count), 0);
    expect_map("col0_r4", 5'd4, 6'd50);
    expect_map("col0_r3", 5'd3, 6'd41);
    do_release("rel_empty", 4'd7, 1'b0);

    // in-order release across the pointer wrap
    save(1'b0, 4'd1); tick(); idle();
    save(1'b0, 4'd2); tick(); idle();
    save(1'b0, 4'd3); tick(); idle();
    check("wrap_count3", 32'(ckpt_count), 3);
    do_release("rel_rob1", 4'd1, 1'b1);
    check("rel1_count", 32'(ckpt_count), 2);
    release_valid = 1'b1; release_ROB_index = 4'd2; save(1'b0, 4'd4);
    #1;
    check("rel_save_rel", 32'(release_success), 1);
    check("rel_save_col", 32'(save_column), 3);
    tick(); idle();
    check("rel_save_count", 32'(ckpt_count), 2);
    check("rel_save_wrap", 32'(save_column), 0);
    do_release("rel_rob3", 4'd3, 1'b1);
    do_release("rel_badtag", 4'd5, 1'b0);
    do_release("rel_rob4", 4'd4, 1'b1);
    check("rel_done_count", 32'(ckpt_count), 0);
    do_release("rel_after_empty", 4'd4, 1'b0);

    // revert wins over a same-cycle rename
    revert_valid = 1'b1; revert_dest_arch_tag = 5'd4;
    revert_safe_phys_tag = 6'd45; revert_spec_phys_tag = 6'd50;
    ren(0, 5'd8, 6'd44);
    tick(); idle();
    expect_map("revert_r4", 5'd4, 6'd45);
    expect_map("revert_r8", 5'd8, 6'd8);

    // arch 0 is hard-wired
    ren(0, 5'd0, 6'd60); src_arch_tag[1][0] = 5'd0;
    #1;
    check("a0_old", 32'(rename_old_phys_tag[0]), 0);
    check("a0_src", 32'(src_phys_tag[1][0]), 0);
    tick(); idle();
    expect_map("a0_after", 5'd0, 6'd0);

    // reset mid-operation drops checkpoints at once
    save(1'b0, 4'd2); ren(0, 5'd9, 6'd12);
    tick(); idle();
    check("pre_rst_count", 32'(ckpt_count), 1);
    nRST = 1'b0;
    #1;
    check("mid_rst_count", 32'(ckpt_count), 0);
    check("mid_rst_col", 32'(save_column), 0);
    expect_map("mid_rst_r9", 5'd9, 6'd9);
    expect_map("mid_rst_r3", 5'd3, 6'd3);
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/phys_reg_map_table_ss.md
# phys_reg_map_table_ss

Superscalar, parametrised physical register map table for the OoO core's dispatch/rename stage. Per cycle it serves `RENAME_WIDTH` rename lanes with intra-group dependency bypass and returns each lane's previous mapping for the ROB and free list. It keeps a circular FIFO of checkpoint columns with save back-pressure, in-order release on branch commit, and restore on mispredict.

## Interface
Parameters:
- `NUM_ARCH_REGS`, 32: architectural registers; arch reg 0 is hard-wired.
- `NUM_PHYS_REGS`, 64: physical registers; tag width `PW = $clog2(NUM_PHYS_REGS)`.
- `CHECKPOINT_COLUMNS`, 4: columns, power of 2; `CW = $clog2(CHECKPOINT_COLUMNS)`.
- `RENAME_WIDTH`, 2: lanes per cycle.
- `ROB_INDEX_W`, 4: ROB index width.

Ports:
- `CLK` in 1: clock.
- `nRST` in 1: reset, asynchronous, active-low.
- `src_arch_tag` in `[RENAME_WIDTH][2]` x `AW`: per-lane source arch regs.
- `src_phys_tag` out `[RENAME_WIDTH][2]` x `PW`: bypassed source mappings.
- `rename_valid` in `RENAME_WIDTH`: lane performs a rename.
- `rename_dest_arch_tag` in `[RENAME_WIDTH]` x `AW`: lane destination arch reg.
- `rename_dest_phys_tag` in `[RENAME_WIDTH]` x `PW`: new physical tag from the free list.
- `rename_old_phys_tag` out `[RENAME_WIDTH]` x `PW`: mapping being overwritten (bypassed).
- `save_valid` in 1: request a checkpoint.
- `save_lane` in `$clog2(RENAME_WIDTH)`: lane of the branch.
- `save_ROB_index` in `ROB_INDEX_W`: branch ROB index.
- `save_ready` out 1: a checkpoint column is free.
- `save_column` out `CW`: column that holds the checkpoint.
- `release_valid` in 1: branch committed correctly.
- `release_ROB_index` in `ROB_INDEX_W`: ROB index of the committing branch.
- `release_success` out 1: release accepted.
- `restore_valid` in 1: mispredict, roll back to a checkpoint.
- `restore_column` in `CW`: column to roll back to.
- `restore_ROB_index` in `ROB_INDEX_W`: ROB index of the mispredicted branch.
- `restore_success` out 1: restore accepted.
- `revert_valid` in 1: undo one rename (ROB walk).
- `revert_dest_arch_tag` in `AW`: arch reg to undo.
- `revert_safe_phys_tag` in `PW`: mapping to write back.
- `revert_spec_phys_tag` in `PW`: mapping being undone.
- `ckpt_count` out `CW`: checkpoints outstanding.

## Operation
- **State.** Per column: `valid`, `ROB_index`, `array[NUM_ARCH_REGS]`. Pointers are `working` (CW) and `count` (CW). `oldest = working - count` mod `CHECKPOINT_COLUMNS`. The working column is always valid.
- **Reads (combinational).** Lane j source = working array entry, overridden by the highest lane i < j with `rename_valid[i]` and the same dest arch. Arch 0 always reads phys 0.
- **Old mapping.** `rename_old_phys_tag[j]` uses the same bypass rule, applied to the lane's dest arch.
- **Renames.** All valid lanes write the working column. For duplicate dest arch, the higher lane wins. Renames to arch 0 are dropped; `old_phys_tag` still reports 0.
- **Save.** Accepted iff `save_valid & save_ready`, where `save_ready = (count != CHECKPOINT_COLUMNS-1)`.
  - The current working column becomes the checkpoint: it holds the mapping after lanes ≤ `save_lane` renames, and its `ROB_index` is set to `save_ROB_index`.
  - Column `working+1` gets `valid=1` and the array with all lanes' renames applied.
  - `working` and `count` each increment by 1.
  - `save_column = working` (combinational).
  - A save while full is ignored, but renames still apply.
- **Release.** Accepted iff `count != 0` and `oldest.valid` and `oldest.ROB_index == release_ROB_index`. On accept, `oldest.valid` clears and `count` decrements.
- **Restore.** Accepted iff `restore_column.valid`, its tag matches `restore_ROB_index`, and `restore_column != working`.
  - `working` becomes `restore_column`.
  - Columns strictly younger than it, up to the old working column, are invalidated.
  - `count` becomes `(restore_column - oldest)` mod C.
  - Renames, save and revert that cycle are ignored.
- **Revert.** Writes `revert_safe_phys_tag` into the working column. An SVA checks that the current mapping equals `revert_spec_phys_tag`. Renames and save that cycle are ignored.
- **Priority.** restore > revert > {save, rename}.
  - Release is evaluated in parallel with the others.
  - If release and restore target the same column, restore wins and `release_success=0`.
  - When release and save coincide, `count` is unchanged.

## Timing
- Reads, `old_phys_tag`, `save_ready`, `save_column` and both success flags are combinational from the current state.
- All state updates take effect at the next `CLK` edge. A rename in cycle N is visible to non-bypassed reads in cycle N+1.
- Reset values:
  - Column 0: `valid=1`, `ROB_index=0`, `array[i]=i`.
  - Other columns: all zero.
  - `working=0`, `count=0`.
  - Outputs after reset: `save_ready=1`, `save_column=0`, `ckpt_count=0`, both success flags 0.
- Asserting `nRST` mid-operation discards all checkpoints immediately.
- Pointer arithmetic wraps modulo `CHECKPOINT_COLUMNS`.

## Structure
- Shared package `core_types_pkg` gains the parameters above (defaults), plus `phys_reg_tag_t`, `arch_reg_tag_t`, `checkpoint_column_t` and `ROB_index_t`.
- The column struct type stays local to this block.
- One sub-module, `rename_bypass_net`, is purely combinational. It takes the per-lane dest/valid lists and produces the bypassed source and old-mapping tags. It is instantiated once.

## Test plan
- **Reset.** Read arch 5 -> phys 5. `save_ready=1`, `ckpt_count=0`.
- **Dual rename with dependency.** Lane0 r3->p40 and lane1 r3->p41, with lane1 src=r3: lane1 src reads p40; `old_phys_tag` = {p3, p40}. Next cycle, r3 reads p41.
- **Save on lane 0 with lane 1 rename.** Lane0 r4->p50, lane1 r4->p51, save ROB 7: `save_column=0`. Column 0 holds r4=p50; working=1 holds r4=p51; `count=1`.
- **Fill checkpoints.** Three saves -> `save_ready=0`. A fourth save is ignored while its renames still apply.
- **Restore.** Restore column 1 with ROB 9 after three saves -> `success=1`, `working=1`, `count=1`, columns 2–3 invalid. A wrong ROB tag -> `success=0`, no state change.
- **Release with wrap.** Release the oldest in order across a pointer wrap; `count` returns to 0. Release with `count=0` -> `success=0`.
